eight_bit_serial_subtractor: RTL and testbench
==============================================

# eight_bit_serial_subtractor

Multi-cycle, bit-serial 8-bit subtractor with borrow chain, the inverse companion to the combinational 8-bit adder. It recovers an operand from a sum: A − B − borrow_in. It resolves one bit per clock from LSB to MSB and reports completion through a start/busy/done handshake. It sits beside the adder in the arithmetic datapath. Its results are checked against the adder by round-trip (A − B then + B).

## Interface
- No parameters; width fixed at 8 bits.
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- A  input  8  minuend, sampled only when a start is accepted
- B  input  8  subtrahend, sampled only when a start is accepted
- borrow_in  input  1  incoming borrow, sampled only when a start is accepted
- start  input  1  request; accepted only in IDLE or DONE
- diff  output  8  registered result (A − B − borrow_in) mod 256
- borrow_out  output  1  registered borrow, 1 iff A < B + borrow_in
- busy  output  1  high while bits are being resolved
- done  output  1  one-cycle pulse, result valid

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge latches A, B and borrow_in into internal registers.
  - Clears the bit counter to 0 and the internal difference shift register to 0.
  - Moves to SHIFT.
- SHIFT, bit i = counter:
  - d = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - br is initialised from borrow_in.
  - d is shifted into the MSB of the internal shift register, which shifts right.
  - The counter increments.
- Bit i=7 processed:
  - diff ← completed shift register; borrow_out ← br_next; state → DONE.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 is accepted exactly as in IDLE (back-to-back). Otherwise → IDLE.
- start in SHIFT is ignored; no queuing. A/B/borrow_in changes during SHIFT have no effect.
- diff and borrow_out change only on the DONE transition. They hold their value indefinitely until the next completion.
- Arithmetic:
  - {borrow_out, diff} is the 9-bit two's-complement wrap of A − B − borrow_in.
  - Operands are unsigned.
  - No overflow flag.

## Timing
- Reset (rst_n=0, asynchronous, any state): state=IDLE, diff=0, borrow_out=0, busy=0, done=0, counter=0. Internal operand registers are cleared.
- Reset mid-SHIFT aborts the operation:
  - No done pulse is issued.
  - diff keeps no partial result (reads 0).
- First edge with rst_n=1 is an ordinary IDLE cycle.
- Start accepted at edge k:
  - busy=1 after edge k.
  - Bits 0..7 are resolved at edges k+1..k+8.
  - After edge k+8: busy=0, done=1, diff/borrow_out valid.
  - After edge k+9: done=0, unless a new start was accepted at k+9.
- Latency: 8 cycles from the accepting edge to done.
- Throughput: one result per 9 cycles with start held high.
- busy and done are never high simultaneously.

## Test plan
- Reset, then A=0, B=0, borrow_in=0, start pulse -> busy high 8 cycles, then done pulse; diff=0, borrow_out=0, done exactly 8 edges after start.
- Sequence of operands, each started in IDLE; check each result at done:
  - 5−3−0 -> diff=2, bo=0
  - 0−1−0 -> diff=255, bo=1
  - 128−128−1 -> diff=255, bo=1
  - 255−0−1 -> diff=254, bo=0
  - 200−250−0 -> diff=206, bo=1
  - 40−6−0 -> diff=34, bo=0
- Start 220−250−1, then assert start with A=1, B=1 on cycles 3..6 of SHIFT -> second request ignored; result diff=225, bo=1. busy is unaffected.
- start held high continuously with new A/B each done cycle -> a done pulse every 9 cycles; each result matches its own operands captured at acceptance.
- Assert rst_n=0 at SHIFT bit 4 of 250−40−0, release, start 30−0−0 -> no done for the aborted op; outputs 0 during reset; next result diff=30, bo=0.
- Round-trip: random 1000 triples, diff fed with B into the adder with carry_in=borrow_in -> sum equals A; carry_out equals borrow_out.

Source files
------------

// File: rtl/eight_bit_serial_subtractor.sv
// Bit-serial 8-bit subtractor: resolves A - B - borrow_in one bit per clock, LSB first,
// with a start/busy/done handshake and registered results.
module eight_bit_serial_subtractor (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       borrow_in,
   input  logic       start,
   output logic [7:0] diff,
   output logic       borrow_out,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0] state_r;
   logic [2:0] count_r;
   logic [7:0] a_r;
   logic [7:0] b_r;
   logic [7:0] sr_r;
   logic       br_r;

   logic       a_bit_s;
   logic       b_bit_s;
   logic       d_s;
   logic       br_next_s;
   logic       accept_s;
   logic [7:0] sr_next_s;

   // One-bit full subtractor: returns {borrow_next, difference_bit}.
   function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
      logic d;
      logic bn;
      d  = a ^ b ^ br;
      bn = (~a & b) | (~(a ^ b) & br);
      return {bn, d};
   endfunction

   // Current-bit selection, bit result and start acceptance.
   always_comb begin
      a_bit_s   = a_r[count_r];
      b_bit_s   = b_r[count_r];
      {br_next_s, d_s} = full_sub(a_bit_s, b_bit_s, br_r);
      sr_next_s = {d_s, sr_r[7:1]};
      accept_s  = start && ((state_r == IDLE) || (state_r == DONE));
   end

   // Sequencer, operand capture and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         count_r    <= 3'd0;
         a_r        <= 8'd0;
         b_r        <= 8'd0;
         sr_r       <= 8'd0;
         br_r       <= 1'b0;
         diff       <= 8'd0;
         borrow_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               done <= 1'b0;
               if (accept_s) begin
                  a_r     <= A;
                  b_r     <= B;
                  br_r    <= borrow_in;
                  count_r <= 3'd0;
                  sr_r    <= 8'd0;
                  busy    <= 1'b1;
                  state_r <= SHIFT;
               end else begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            SHIFT: begin
               sr_r    <= sr_next_s;
               br_r    <= br_next_s;
               count_r <= count_r + 3'd1;
               // Results are published only on the final bit so they never show partial sums.
               if (count_r == 3'd7) begin
                  diff       <= sr_next_s;
                  borrow_out <= br_next_s;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state_r    <= DONE;
               end else begin
                  busy       <= 1'b1;
                  done       <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eight_bit_serial_subtractor.sv
// Directed and round-trip bench for the bit-serial subtractor.
module tb_eight_bit_serial_subtractor;

   logic       clk;
   logic       rst_n;
   logic [7:0] A;
   logic [7:0] B;
   logic       borrow_in;
   logic       start;
   logic [7:0] diff;
   logic       borrow_out;
   logic       busy;
   logic       done;

   int checks;
   int errors;

   eight_bit_serial_subtractor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .A          (A),
      .B          (B),
      .borrow_in  (borrow_in),
      .start      (start),
      .diff       (diff),
      .borrow_out (borrow_out),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Wait for a done pulse, sampling on negedges; returns number of edges waited and busy count.
   task automatic wait_done(output int edges, output int busy_cnt);
      edges    = 0;
      busy_cnt = 0;
      do begin
         @(negedge clk);
         edges++;
         if (busy === 1'b1) busy_cnt++;
         if (busy === 1'b1 && done === 1'b1) chk("busy_and_done", 32'd1, 32'd0);
      end while (done !== 1'b1 && edges < 30);
   endtask

   // One operation started from IDLE; exp is {borrow_out, diff}.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [8:0] exp, input string tag);
      int edges;
      int bc;
      @(negedge clk);
      A = a; B = b; borrow_in = bi; start = 1'b1;
      wait_done(edges, bc);
      start = 1'b0;
      chk({tag, "_latency"}, edges, 32'd9);
      chk({tag, "_busy_cycles"}, bc, 32'd8);
      chk({tag, "_busy_at_done"}, busy, 32'd0);
      chk({tag, "_diff"}, diff, exp[7:0]);
      chk({tag, "_bo"}, borrow_out, exp[8]);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 32'd0);
      chk({tag, "_diff_hold"}, diff, exp[7:0]);
   endtask

   initial begin
      logic [8:0] model;
      logic [8:0] sum;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rbi;
      logic [7:0] bb_a [4];
      logic [7:0] bb_b [4];
      logic [8:0] bb_e [4];
      int edges;
      int bc;
      int done_seen;

      checks = 0; errors = 0;
      rst_n = 1'b0; A = 8'd0; B = 8'd0; borrow_in = 1'b0; start = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_diff", diff, 32'd0);
      chk("rst_bo", borrow_out, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_done", done, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(8'd0,   8'd0,   1'b0, 9'd0,   "zero");
      do_op(8'd5,   8'd3,   1'b0, 9'd2,   "5m3");
      do_op(8'd0,   8'd1,   1'b0, 9'h1FF, "0m1");
      do_op(8'd128, 8'd128, 1'b1, 9'h1FF, "128m128b");
      do_op(8'd255, 8'd0,   1'b1, 9'd254, "255m0b");
      do_op(8'd200, 8'd250, 1'b0, 9'h1CE, "200m250");
      do_op(8'd40,  8'd6,   1'b0, 9'd34,  "40m6");

      // Start requests during SHIFT must be ignored.
      @(negedge clk);
      A = 8'd220; B = 8'd250; borrow_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      A = 8'd1; B = 8'd1; borrow_in = 1'b0; start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("ign_busy", busy, 32'd1);
      end
      start = 1'b0;
      wait_done(edges, bc);
      chk("ign_latency", edges, 32'd2);
      chk("ign_diff", diff, 32'd225);
      chk("ign_bo", borrow_out, 32'd1);
      @(negedge clk);
      chk("ign_no_second", busy, 32'd0);
      chk("ign_done_low", done, 32'd0);

      // start held high: a new result every 9 cycles.
      bb_a[0] = 8'd10;  bb_b[0] = 8'd20;  bb_e[0] = 9'h1F6;
      bb_a[1] = 8'd99;  bb_b[1] = 8'd33;  bb_e[1] = 9'd66;
      bb_a[2] = 8'd7;   bb_b[2] = 8'd7;   bb_e[2] = 9'd0;
      bb_a[3] = 8'd1;   bb_b[3] = 8'd255; bb_e[3] = 9'h102;
      @(negedge clk);
      A = bb_a[0]; B = bb_b[0]; borrow_in = 1'b0; start = 1'b1;
      for (int j = 0; j < 4; j++) begin
         wait_done(edges, bc);
         chk($sformatf("b2b%0d_period", j), edges, 32'd9);
         chk($sformatf("b2b%0d_diff", j), diff, bb_e[j][7:0]);
         chk($sformatf("b2b%0d_bo", j), borrow_out, bb_e[j][8]);
         if (j < 3) begin
            A = bb_a[j+1]; B = bb_b[j+1];
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      chk("b2b_idle", busy, 32'd0);

      // Reset in the middle of SHIFT aborts the operation.
      @(negedge clk);
      A = 8'd250; B = 8'd40; borrow_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_busy_before", busy, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_diff", diff, 32'd0);
      chk("abort_bo", borrow_out, 32'd0);
      chk("abort_busy", busy, 32'd0);
      chk("abort_done", done, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      chk("abort_no_done", done_seen, 32'd0);
      chk("abort_diff_after", diff, 32'd0);
      do_op(8'd30, 8'd0, 1'b0, 9'd30, "after_rst");

      // Round trip through an adder model: diff + B + borrow_in must restore A.
      for (int n = 0; n < 1000; n++) begin
         ra  = 8'($urandom_range(255));
         rb  = 8'($urandom_range(255));
         rbi = 1'($urandom_range(1));
         model = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
         @(negedge clk);
         A = ra; B = rb; borrow_in = rbi; start = 1'b1;
         wait_done(edges, bc);
         start = 1'b0;
         chk("rt_latency", edges, 32'd9);
         chk("rt_model", {borrow_out, diff}, model);
         sum = {1'b0, diff} + {1'b0, rb} + {8'd0, rbi};
         chk("rt_sum", sum[7:0], ra);
         chk("rt_carry", sum[8], borrow_out);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
